// File: rtl/tsm_pkg.sv
// Shared types and defaults for the traffic scheduler (TSM) and its arbiter.
package tsm_pkg;

  typedef enum logic [1:0] {
    IDLE_S      = 2'd0,
    GRANT_S     = 2'd1,
    WAIT_DONE_S = 2'd2,
    HOLDOFF_S   = 2'd3
  } tsm_state_e;

  localparam int unsigned TSM_NUM_Q   = 8;
  localparam int unsigned TSM_QID_W   = 3;
  localparam int unsigned HOLDOFF_MIN = 2;

endpackage

// File: rtl/tsm_rr_arbiter.sv
// Combinational masked priority encoder: round-robin from a pointer, or
// strict lowest-index-first when mode_i is set.
import tsm_pkg::*;

module tsm_rr_arbiter #(
  parameter int unsigned NUM_Q = TSM_NUM_Q,
  parameter int unsigned QID_W = TSM_QID_W
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [QID_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [QID_W-1:0] winner_o,
  output logic             any_req_o
);

  logic             found;
  logic [QID_W:0]   sum;
  logic [QID_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_Q; k++) begin
      // Wrapped offset from the pointer; never exceeds 2*(NUM_Q-1).
      sum = {1'b0, ptr_i} + (QID_W+1)'(k);
      if (sum >= (QID_W+1)'(NUM_Q)) begin
        sum = sum - (QID_W+1)'(NUM_Q);
      end
      idx = mode_i ? QID_W'(k) : sum[QID_W-1:0];
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = idx;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/tgr_scheduler.sv
// Traffic scheduler: grants one TGR queue at a time to the packet generator,
// pulses the winner's selected line, then holds off so token state settles.
import tsm_pkg::*;

module tgr_scheduler #(
  parameter int unsigned NUM_Q          = TSM_NUM_Q,
  parameter int unsigned QID_W          = TSM_QID_W,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_stop,
  input  logic             in_tsm_prio_mode,
  input  logic [NUM_Q-1:0] in_tsm_req,
  output logic [NUM_Q-1:0] out_tsm_selected,
  output logic             out_tsm_gen_valid,
  output logic [QID_W-1:0] out_tsm_gen_qid,
  input  logic             in_tsm_gen_ready,
  input  logic             in_tsm_gen_done,
  output logic [31:0]      out_tsm_grant_cnt
);

  localparam int unsigned HOLDOFF_EFF =
    (HOLDOFF_CYCLES < HOLDOFF_MIN) ? HOLDOFF_MIN : HOLDOFF_CYCLES;
  localparam int unsigned HO_W = $clog2(HOLDOFF_EFF);

  tsm_state_e       state_q;
  logic [QID_W-1:0] ptr_q;
  logic [QID_W-1:0] ptr_d;
  logic [HO_W-1:0]  ho_cnt_q;
  logic             valid_q;
  logic [QID_W-1:0] qid_q;
  logic [NUM_Q-1:0] sel_q;
  logic [NUM_Q-1:0] sel_d;
  logic [31:0]      cnt_q;
  logic [QID_W-1:0] arb_winner;
  logic             arb_any;

  tsm_rr_arbiter #(
    .NUM_Q (NUM_Q),
    .QID_W (QID_W)
  ) u_arb (
    .req_i     (in_tsm_req),
    .ptr_i     (ptr_q),
    .mode_i    (in_tsm_prio_mode),
    .winner_o  (arb_winner),
    .any_req_o (arb_any)
  );

  always_comb begin
    ptr_d = (qid_q == QID_W'(NUM_Q-1)) ? '0 : qid_q + QID_W'(1);
    sel_d = '0;
    sel_d[qid_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE_S;
      ptr_q    <= '0;
      ho_cnt_q <= '0;
      valid_q  <= 1'b0;
      qid_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      sel_q <= '0;
      case (state_q)
        IDLE_S: begin
          if (!test_stop && arb_any) begin
            qid_q   <= arb_winner;
            valid_q <= 1'b1;
            state_q <= GRANT_S;
          end
        end
        GRANT_S: begin
          // Committed grant: request drops and test_stop are ignored here.
          if (in_tsm_gen_ready) begin
            valid_q <= 1'b0;
            sel_q   <= sel_d;
            cnt_q   <= cnt_q + 32'd1;
            ptr_q   <= ptr_d;
            state_q <= WAIT_DONE_S;
          end
        end
        WAIT_DONE_S: begin
          if (in_tsm_gen_done) begin
            ho_cnt_q <= HO_W'(HOLDOFF_EFF - 1);
            state_q  <= HOLDOFF_S;
          end
        end
        HOLDOFF_S: begin
          if (ho_cnt_q == '0) begin
            state_q <= IDLE_S;
          end else begin
            ho_cnt_q <= ho_cnt_q - HO_W'(1);
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign out_tsm_selected  = sel_q;
  assign out_tsm_gen_valid = valid_q;
  assign out_tsm_gen_qid   = qid_q;
  assign out_tsm_grant_cnt = cnt_q;

endmodule

// File: tb/tb_tgr_scheduler.sv
// Directed bench for tgr_scheduler with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_tgr_scheduler;

  localparam int NQ = 8;
  localparam int HO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_stop = 1'b0;
  logic        prio = 1'b0;
  logic [7:0]  req = 8'h00;
  logic [7:0]  sel;
  logic        valid;
  logic [2:0]  qid;
  logic        ready = 1'b0;
  logic        done = 1'b0;
  logic [31:0] gcnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tgr_scheduler #(
    .NUM_Q          (8),
    .QID_W          (3),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .test_stop         (test_stop),
    .in_tsm_prio_mode  (prio),
    .in_tsm_req        (req),
    .out_tsm_selected  (sel),
    .out_tsm_gen_valid (valid),
    .out_tsm_gen_qid   (qid),
    .in_tsm_gen_ready  (ready),
    .in_tsm_gen_done   (done),
    .out_tsm_grant_cnt (gcnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: phase 0 = free, 1 = offered, 2 = in generator, 3 = cooling.
  int          m_phase = 0;
  int          m_cool = 0;
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_qid = 3'd0;
  logic [7:0]  m_sel = 8'h00;
  logic [31:0] m_cnt = 32'd0;

  function automatic logic [2:0] pick(input logic [7:0] r, input logic strict, input int p);
    for (int k = 0; k < NQ; k++) begin
      int i;
      i = strict ? k : (p + k) % NQ;
      if (r[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cool = 0; m_ptr = 0;
      m_valid = 1'b0; m_qid = 3'd0; m_sel = 8'h00; m_cnt = 32'd0;
    end else begin
      m_sel = 8'h00;
      case (m_phase)
        0: if (!test_stop && req != 8'h00) begin
             m_qid = pick(req, prio, m_ptr);
             m_valid = 1'b1;
             m_phase = 1;
           end
        1: if (ready) begin
             m_valid = 1'b0;
             m_sel = 8'd1 << m_qid;
             m_cnt = m_cnt + 32'd1;
             m_ptr = (int'(m_qid) + 1) % NQ;
             m_phase = 2;
           end
        2: if (done) begin
             m_cool = HO;
             m_phase = 3;
           end
        default: begin
          m_cool = m_cool - 1;
          if (m_cool == 0) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      if (m_valid) chk("qid", {29'd0, qid}, {29'd0, m_qid});
      chk("selected", {24'd0, sel}, {24'd0, m_sel});
      chk("grant_cnt", gcnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 40) begin
      step();
      n++;
    end
    if (!valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input int rdy_delay, input bit done_at_hs, output logic [2:0] q);
    logic [7:0] one;
    wait_valid();
    q = qid;
    repeat (rdy_delay) step();
    ready = 1'b1;
    if (done_at_hs) done = 1'b1;
    step();
    ready = 1'b0;
    done = 1'b0;
    one = 8'd1 << q;
    chk("sel_onehot", {24'd0, sel}, {24'd0, one});
    chk("valid_drop", {31'd0, valid}, 32'd0);
    step();
    chk("sel_single", {24'd0, sel}, 32'd0);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [2:0] q;
  logic [2:0] exp_rr [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    // Test 1: idle after reset, stray done ignored
    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_cnt", gcnt, 32'd0);
    for (int c = 0; c < 20; c++) begin
      done = (c == 10);
      step();
    end
    done = 1'b0;
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_sel", {24'd0, sel}, 32'd0);
    chk("idle_cnt", gcnt, 32'd0);

    // Test 2: round-robin fairness; one handshake coincides with a done
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      serve(0, (g == 3), q);
      chk("rr_qid", {29'd0, q}, {29'd0, exp_rr[g]});
    end
    chk("rr_cnt9", gcnt, 32'd9);

    // Test 3: strict priority, then back to RR from pointer 3
    prio = 1'b1;
    req = 8'b1010_0100;
    for (int g = 0; g < 3; g++) begin
      serve(1, 1'b0, q);
      chk("strict_qid", {29'd0, q}, 32'd2);
    end
    prio = 1'b0;
    serve(0, 1'b0, q);
    chk("rr_after_strict_a", {29'd0, q}, 32'd5);
    serve(0, 1'b0, q);
    chk("rr_after_strict_b", {29'd0, q}, 32'd7);

    // Test 4: backpressure with request withdrawn
    req = 8'h10;
    wait_valid();
    req = 8'h00;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", {31'd0, valid}, 32'd1);
      chk("bp_qid", {29'd0, qid}, 32'd4);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("bp_sel", {24'd0, sel}, 32'h10);
    step();
    chk("bp_sel_clear", {24'd0, sel}, 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;

    // Test 5: test_stop raised during WAIT_DONE
    req = 8'hFF;
    wait_valid();
    chk("ts_qid", {29'd0, qid}, 32'd5);
    ready = 1'b1;
    step();
    ready = 1'b0;
    test_stop = 1'b1;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (15) step();
    chk("ts_blocked", {31'd0, valid}, 32'd0);
    test_stop = 1'b0;
    step();
    chk("ts_resume_valid", {31'd0, valid}, 32'd1);
    chk("ts_resume_qid", {29'd0, qid}, 32'd6);

    // Test 6: done during GRANT ignored, then async reset mid-GRANT
    done = 1'b1;
    step();
    done = 1'b0;
    chk("done_in_grant_valid", {31'd0, valid}, 32'd1);
    chk("done_in_grant_qid", {29'd0, qid}, 32'd6);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_qid", {29'd0, qid}, 32'd0);
    chk("arst_sel", {24'd0, sel}, 32'd0);
    chk("arst_cnt", gcnt, 32'd0);
    ready = 1'b1;
    step();
    step();
    chk("arst_no_sel", {24'd0, sel}, 32'd0);
    ready = 1'b0;
    rst_n = 1'b1;
    serve(0, 1'b0, q);
    chk("post_reset_qid", {29'd0, q}, 32'd0);
    chk("post_reset_cnt", gcnt, 32'd1);
    repeat (5) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
